// File: rtl/pe_arb_pkg.sv
// -----------------------------------------------------------------------------
// pe_arb_pkg
// Shared definitions for the PE load arbiter: controller state encoding, the
// two slice PE codes the controller drives, and the slice data width.
// -----------------------------------------------------------------------------
package pe_arb_pkg;

    localparam int DW = 4;

    // Slice PE codes. Any code other than HOLD makes a slice load; the
    // controller only ever drives these two.
    localparam logic [1:0] PE_HOLD = 2'b11;
    localparam logic [1:0] PE_LOAD = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pe_load_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the request
// vector and the priority pointer; the pointer only moves when both inputs
// compete during an update, so a lone requester never steals priority.
//
// Ports:
//   clk     in   rising-edge clock
//   r       in   asynchronous reset, active-low (pointer -> requester 0)
//   req     in   [1:0] request vector
//   update  in   arbitration decision is being taken this cycle
//   gnt     out  [1:0] one-hot grant (zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       r,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After a tie the loser gets priority, so it is served next.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            ptr <= 1'b0;
        end else if (update && (req == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/pe_load_arbiter.sv
// -----------------------------------------------------------------------------
// pe_load_arbiter
// Lets two requesters write a bank of NREG 4-bit parallel-load slices. A
// write is granted round-robin, drives PE=00 on exactly one slice for one
// cycle with D = ~wdata (slices store D and present it inverted on Q, and
// capture on the falling clock edge), then answers with a four-phase ack.
//
// Ports:
//   clk            in   clock; controller on rising edge
//   r              in   asynchronous reset, active-low
//   req0/req1      in   write request levels
//   addr0/addr1    in   [AW-1:0] target slice index
//   wdata0/wdata1  in   [3:0] value wanted on the slice Q
//   ack0/ack1      out  acknowledge levels, held until req drops
//   err            out  qualifies ackN: address was out of range, no load
//   pe             out  [2*NREG-1:0] per-slice PE, slice i at [2i+1:2i]
//   d              out  [3:0] shared slice data bus
//   busy           out  controller not idle
// -----------------------------------------------------------------------------
module pe_load_arbiter
    import pe_arb_pkg::*;
#(
    parameter int NREG = 4,  // 2..16
    parameter int AW   = 2   // 2**AW >= NREG
) (
    input  logic              clk,
    input  logic              r,
    input  logic              req0,
    input  logic [AW-1:0]     addr0,
    input  logic [DW-1:0]     wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     wdata1,
    output logic              ack1,
    output logic              err,
    output logic [2*NREG-1:0] pe,
    output logic [DW-1:0]     d,
    output logic              busy
);

    state_t             state, state_n;
    logic               gsel, gsel_n;     // granted requester
    logic               eflag, eflag_n;   // granted address was out of range
    logic [2*NREG-1:0]  pe_n;
    logic [DW-1:0]      d_n;
    logic               ack0_n, ack1_n, err_n, busy_n;

    logic [1:0]         gnt;
    logic               arb_update;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic               sel_in_range;
    logic               req_granted;

    rr_arb2 u_arb (
        .clk    (clk),
        .r      (r),
        .req    ({req1, req0}),
        .update (arb_update),
        .gnt    (gnt)
    );

    always_comb begin
        arb_update   = (state == IDLE);
        sel_addr     = gnt[1] ? addr1 : addr0;
        sel_data     = gnt[1] ? wdata1 : wdata0;
        sel_in_range = (int'(sel_addr) < NREG);
        req_granted  = gsel ? req1 : req0;
    end

    // Next state and next registered outputs. pe and d are computed one
    // state ahead so that they are registered and valid for the whole LOAD
    // cycle; PE defaults to all-hold, which also guarantees at most one
    // slice is ever loading.
    always_comb begin
        state_n = state;
        gsel_n  = gsel;
        eflag_n = eflag;
        pe_n    = {NREG{PE_HOLD}};
        d_n     = d;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    gsel_n = gnt[1];
                    if (sel_in_range) begin
                        state_n = LOAD;
                        eflag_n = 1'b0;
                        d_n     = ~sel_data;
                        for (int i = 0; i < NREG; i++) begin
                            if (int'(sel_addr) == i) begin
                                pe_n[2*i +: 2] = PE_LOAD;
                            end
                        end
                    end else begin
                        state_n = DONE;
                        eflag_n = 1'b1;
                    end
                end
            end

            LOAD: begin
                state_n = DONE;
            end

            DONE: begin
                // Only the granted requester's level matters here; the other
                // side simply stays pending until we are back in IDLE.
                if (req_granted) begin
                    ack0_n = ~gsel;
                    ack1_n = gsel;
                    err_n  = eflag;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= IDLE;
            gsel  <= 1'b0;
            eflag <= 1'b0;
            pe    <= {NREG{PE_HOLD}};
            d     <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            gsel  <= gsel_n;
            eflag <= eflag_n;
            pe    <= pe_n;
            d     <= d_n;
            ack0  <= ack0_n;
            ack1  <= ack1_n;
            err   <= err_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_pe_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pe_load_arbiter
// Directed and randomized handshakes against pe_load_arbiter (NREG=5, AW=3 so
// that both the last valid index and out-of-range indices are reachable).
// A small slice model turns pe/d into slice Q values; the expected bank
// contents, grant order and error flags come from a reference model that only
// knows the rules: tie goes to the pointer, which then flips; in-range writes
// store wdata; out-of-range writes store nothing and report err.
// -----------------------------------------------------------------------------
module tb_pe_load_arbiter;

    localparam int NREG = 5;
    localparam int AW   = 3;
    localparam logic [2*NREG-1:0] ALL_HOLD = '1;

    logic              clk = 1'b0;
    logic              r;
    logic              req0, req1;
    logic [AW-1:0]     addr0, addr1;
    logic [3:0]        wdata0, wdata1;
    logic              ack0, ack1, err, busy;
    logic [2*NREG-1:0] pe;
    logic [3:0]        d;

    pe_load_arbiter #(.NREG(NREG), .AW(AW)) dut (
        .clk    (clk),
        .r      (r),
        .req0   (req0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .ack0   (ack0),
        .req1   (req1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .ack1   (ack1),
        .err    (err),
        .pe     (pe),
        .d      (d),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice bank: falling-edge capture when PE != 11, Q is the stored value
    // inverted, cleared by the shared system reset.
    logic [3:0] slice_st [NREG];
    always @(negedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < NREG; i++) slice_st[i] <= 4'h0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (pe[2*i +: 2] != 2'b11) slice_st[i] <= d;
        end
    end

    function automatic logic [3:0] slice_q(input int i);
        return ~slice_st[i];
    endfunction

    // Reference model state
    logic [3:0] exp_q [NREG];
    int         ptr_m;
    int         last_ack_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // At most one slice loading, every cycle out of reset.
    always @(negedge clk) begin : mon
        int act;
        if (r === 1'b1) begin
            act = 0;
            for (int i = 0; i < NREG; i++)
                if (pe[2*i +: 2] !== 2'b11) act++;
            chk("pe_single_active", (act <= 1) ? 1 : 0, 1);
        end
    end

    task automatic set_req(input int who, input logic v, input logic [AW-1:0] a, input logic [3:0] w);
        if (who == 0) begin
            req0 = v; addr0 = a; wdata0 = w;
        end else begin
            req1 = v; addr1 = a; wdata1 = w;
        end
    endtask

    function automatic logic ack_of(input int who);
        return (who == 0) ? ack0 : ack1;
    endfunction

    task automatic check_slices(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s_q%0d", tag, i), slice_q(i), exp_q[i]);
    endtask

    // Full handshake for requester 'who', whose request is already high and
    // which the model expects to be granted at the next rising edge.
    task automatic serve(input int who, input logic [AW-1:0] a, input logic [3:0] w,
                         input int hold, input bit toggle, input string tag);
        int n, loads;
        bit pe_ok, inr;
        logic [2*NREG-1:0] exp_pe;
        inr    = (int'(a) < NREG);
        exp_pe = ALL_HOLD;
        if (inr) exp_pe[2*int'(a) +: 2] = 2'b00;
        n = 0; loads = 0; pe_ok = 1'b1;
        while (ack_of(who) !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (pe !== ALL_HOLD) begin
                loads++;
                if (pe !== exp_pe || d !== ~w) pe_ok = 1'b0;
            end
        end
        last_ack_cyc = cyc;
        chk({tag, "_latency"}, n, inr ? 3 : 2);
        chk({tag, "_ack"}, ack_of(who), 1);
        chk({tag, "_other_ack"}, ack_of(1 - who), 0);
        chk({tag, "_err"}, err, inr ? 0 : 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_loads"}, loads, inr ? 1 : 0);
        chk({tag, "_pe_d"}, pe_ok, 1);
        if (inr) exp_q[int'(a)] = w;
        check_slices({tag, "_slices"});
        for (int k = 0; k < hold; k++) begin
            if (toggle) set_req(1 - who, 1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom));
            @(posedge clk); #1;
            chk({tag, "_hold_ack"}, ack_of(who), 1);
            chk({tag, "_hold_pe"}, pe, ALL_HOLD);
            check_slices({tag, "_hold"});
        end
        if (toggle) set_req(1 - who, 1'b0, '0, '0);
        set_req(who, 1'b0, a, w);
        @(posedge clk); #1;
        chk({tag, "_ack_drop"}, ack_of(who), 0);
        chk({tag, "_err_drop"}, err, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic contend(input logic [AW-1:0] a0, input logic [3:0] w0,
                           input logic [AW-1:0] a1, input logic [3:0] w1,
                           input int hold, input string tag);
        int first;
        set_req(0, 1'b1, a0, w0);
        set_req(1, 1'b1, a1, w1);
        first = ptr_m;
        ptr_m = 1 - ptr_m;
        if (first == 0) begin
            serve(0, a0, w0, hold, 1'b0, {tag, "_r0first"});
            serve(1, a1, w1, hold, 1'b0, {tag, "_r1second"});
        end else begin
            serve(1, a1, w1, hold, 1'b0, {tag, "_r1first"});
            serve(0, a0, w0, hold, 1'b0, {tag, "_r0second"});
        end
    endtask

    initial begin
        int t_prev;
        logic [2*NREG-1:0] mid_pe;

        r = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        for (int i = 0; i < NREG; i++) exp_q[i] = 4'hF;
        ptr_m = 0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pe", pe, ALL_HOLD);
        chk("rst_d", d, 4'h0);
        chk("rst_acks", {ack0, ack1, err}, 3'b000);
        chk("rst_busy", busy, 0);
        r = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_pe", pe, ALL_HOLD);
        chk("post_rst_busy", busy, 0);
        check_slices("rst");

        // Single write
        set_req(0, 1'b1, 3'd2, 4'hA);
        serve(0, 3'd2, 4'hA, 1, 1'b0, "single");
        chk("single_slice2", slice_q(2), 4'hA);

        // Contention twice: requester 0 first, then requester 1 first
        contend(3'd1, 4'h3, 3'd3, 4'hC, 0, "cont_a");
        contend(3'd1, 4'h5, 3'd3, 4'h6, 1, "cont_b");

        // Range boundary: last valid index, then out of range
        set_req(0, 1'b1, 3'd4, 4'h7);
        serve(0, 3'd4, 4'h7, 0, 1'b0, "last_idx");
        set_req(1, 1'b1, 3'd5, 4'hB);
        serve(1, 3'd5, 4'hB, 0, 1'b0, "oor5");
        set_req(1, 1'b1, 3'd7, 4'h2);
        serve(1, 3'd7, 4'h2, 2, 1'b1, "oor7");

        // Back-to-back from one requester
        set_req(0, 1'b1, 3'd0, 4'h1);
        serve(0, 3'd0, 4'h1, 0, 1'b0, "b2b0");
        for (int j = 1; j < 4; j++) begin
            t_prev = last_ack_cyc;
            set_req(0, 1'b1, 3'(j), 4'(j * 3 + 1));
            serve(0, 3'(j), 4'(j * 3 + 1), 0, 1'b0, $sformatf("b2b%0d", j));
            chk($sformatf("b2b%0d_turnaround", j), last_ack_cyc - t_prev, 4);
        end

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int mode;
            logic [AW-1:0] ra0, ra1;
            logic [3:0] rw0, rw1;
            mode = $urandom_range(0, 2);
            ra0 = 3'($urandom); ra1 = 3'($urandom);
            rw0 = 4'($urandom); rw1 = 4'($urandom);
            if (mode == 2) begin
                contend(ra0, rw0, ra1, rw1, $urandom_range(0, 2), "rand_cont");
            end else if (mode == 0) begin
                set_req(0, 1'b1, ra0, rw0);
                serve(0, ra0, rw0, $urandom_range(0, 3), 1'b1, "rand_r0");
            end else begin
                set_req(1, 1'b1, ra1, rw1);
                serve(1, ra1, rw1, $urandom_range(0, 3), 1'b1, "rand_r1");
            end
        end

        // Reset in the middle of a load; pointer must also return to 0
        if (ptr_m == 0) contend(3'd2, 4'h8, 3'd3, 4'h4, 0, "pre_rst");
        set_req(0, 1'b1, 3'd0, 4'h9);
        mid_pe = ALL_HOLD;
        mid_pe[1:0] = 2'b00;
        @(posedge clk); #1;
        chk("midload_pe_active", pe, mid_pe);
        #1 r = 1'b0;
        #1;
        chk("midload_rst_pe", pe, ALL_HOLD);
        chk("midload_rst_busy", busy, 0);
        chk("midload_rst_d", d, 4'h0);
        chk("midload_rst_ack", ack0, 0);
        set_req(0, 1'b0, '0, '0);
        for (int i = 0; i < NREG; i++) exp_q[i] = 4'hF;
        ptr_m = 0;
        @(posedge clk); #1;
        check_slices("midload_rst");
        r = 1'b1;
        @(posedge clk); #1;
        contend(3'd0, 4'h6, 3'd1, 4'hE, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_load_arbiter.md
Name: pe_load_arbiter

Overview:
- Shares a bank of NREG 4-bit parallel-load register slices between two requesters.
- Each slice has a 2-bit PE control and a 4-bit shared D bus:
  - PE = 2'b11 holds; any other PE loads.
  - The slice captures on the falling edge of clk.
  - The slice's Q output is the inverse of the stored bit, so reset leaves Q = 4'hF.
- This block arbitrates round-robin, drives PE and D for exactly one slice per write, and returns a four-phase acknowledge.

Parameters:
- NREG, 4: number of register slices controlled (2..16).
- AW, 2: requester address width. Must satisfy 2**AW >= NREG.

Ports:
- clk  in  1  system clock. Controller logic on rising edge; slices capture on falling edge.
- r  in  1  asynchronous reset, active-low.
- req0  in  1  requester 0 write request (level).
- addr0  in  AW  requester 0 target slice index.
- wdata0  in  4  requester 0 value wanted on the slice's Q.
- ack0  out  1  requester 0 acknowledge (level, four-phase).
- req1, addr1, wdata1, ack1: same as above, for requester 1.
- err  out  1  valid with ackN. 1 = address out of range, no load done.
- pe  out  2*NREG  per-slice PE. Slice i uses pe[2i+1:2i].
- d  out  4  shared slice data bus.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (r low, asynchronous), applied in any state including mid-LOAD:
  - state = IDLE
  - all pe = 2'b11
  - d = 4'h0
  - ack0 = ack1 = err = busy = 0
  - priority pointer = requester 0
  - A load in progress is abandoned. Slice contents are not touched by this block.
- States: IDLE, LOAD, DONE.
- IDLE, on each rising edge:
  - If any reqN is high, arbitrate. With one request, grant it. With two, grant the requester the pointer names, then flip the pointer to the other requester.
  - Latch the grant, addr and wdata.
  - If addr < NREG: go to LOAD.
  - If addr >= NREG: go directly to DONE with err = 1.
- LOAD, exactly one cycle:
  - pe for the target slice = 2'b00; all other slices = 2'b11.
  - d = ~wdata, so the slice's Q equals wdata after the falling edge inside this cycle.
  - Next rising edge: pe returns to all 2'b11 and the state goes to DONE.
- DONE:
  - ack of the granted requester = 1; err = the latched error flag.
  - Stay in DONE while that requester's req is high.
  - When it is sampled low: ack = 0, err = 0, go to IDLE.
  - The other requester's req is ignored in this state.
- d holds its last value outside LOAD. Its value is only meaningful in LOAD.
- Latency:
  - req is sampled at edge k.
  - pe is active in cycle k..k+1; the slice's Q updates at the falling edge of that cycle.
  - ack goes high at edge k+2.
  - Minimum turnaround, req back-to-back from the same requester: 4 cycles.
- Simultaneous events:
  - Both requests high in IDLE: grant per pointer. The loser stays pending and is served next, so neither requester starves.
  - Requester deasserts req before ack: protocol violation. The grant is still completed.
- Invariant: at most one slice has pe != 2'b11 in any cycle.

Decomposition:
- Package pe_arb_pkg holds:
  - state enum {IDLE, LOAD, DONE}
  - PE_HOLD = 2'b11
  - PE_LOAD = 2'b00
  - data width constant DW = 4
- One sub-module: rr_arb2.
  - Two-input round-robin arbiter holding the priority pointer.
  - Ports: clk, r, req[1:0], update, gnt[1:0].
- The PE decoder and FSM stay in the top module.

Test Plan:
- Reset: hold r low, then release → pe = all 1s, d = 0, acks = 0, busy = 0; bench slice model Q = 4'hF. Assert r low mid-LOAD → pe = all 1s immediately.
- Single write: req0 = 1, addr0 = 2, wdata0 = 4'hA → pe[5:4] = 00 for one cycle; d = 4'h5; slice 2 Q = 4'hA; ack0 high at edge k+2 until req0 drops; err = 0.
- Contention: req0 and req1 rise together (addr 1/3, data 4'h3/4'hC) → requester 0 served first, then requester 1; repeat → requester 1 served first.
- Out of range (NREG = 3, AW = 2): req1 = 1, addr1 = 3 → no pe activity; ack1 = 1 with err = 1 one cycle after the request is sampled.
- Hold semantics: after several writes, random req toggling while in DONE → non-target slices keep their Q values; never more than one slice has pe != 11.
- Back-to-back: req0 held continuously with new data each handshake → 4-cycle turnaround; each write lands in the correct slice.
